fft_r22sdf_wm_seq: RTL and testbench
====================================

# fft_r22sdf_wm_seq

Operand sequencer feeding the time-shared Karatsuba twiddle multiplier of each R22SDF stage. It detects clk_i word boundaries in the clk_3x_i domain via a toggle from the butterfly stage. On each boundary it captures one butterfly output word, its twiddle and its counter, and holds them stable for exactly three clk_3x_i cycles. A phase index aligned to the clk_i boundary drives the multiplier's three DSP passes. A lock FSM qualifies the output and reports phase slips.

## Interface
- DW, 25, data sample width (signed)
- TWIDDLE_WIDTH, 10, twiddle width (signed)
- NLOG2, 10, FFT counter width
- SLIPW, 8, slip counter width

- clk_3x_i  in  1  3x clock, phase-aligned integer multiple of clk_i
- rst_n  in  1  reset; synchronous, active-low
- tog_i  in  1  clk_i-domain flop, inverted every clk_i cycle by upstream
- valid_i  in  1  clk_i-domain word valid
- ctr_i  in  NLOG2  clk_i-domain FFT counter
- x_re_i, x_im_i  in  DW each  butterfly output word
- w_re_i, w_im_i  in  TWIDDLE_WIDTH each  twiddle for this word
- x_re_o, x_im_o, w_re_o, w_im_o  out  DW / TWIDDLE_WIDTH  held operands
- ctr_o  out  NLOG2  held counter
- phase_o  out  2  multiplier pass index 0,1,2
- valid_o  out  1  held word valid and sequencer locked
- locked_o  out  1  FSM in LOCKED
- slip_o  out  1  one-cycle slip pulse
- slip_cnt_o  out  SLIPW  saturating slip count

## Operation
- tog_q samples tog_i every cycle.
- edge = tog_i ^ tog_q, combinational at the current clk_3x_i edge.
- On edge, in any state:
  - capture x, w, ctr_i and valid_i into the holding registers;
  - phase <= 0.
- Without edge: phase <= (phase==2) ? 0 : phase+1. Holding registers keep their value.
- phase_o is the phase register. Operand outputs are the holding registers.
- FSM states: SEARCH, ACQUIRE, LOCKED. "Edge on time" means edge while phase==2.
- SEARCH:
  - edge: go to ACQUIRE;
  - no edge: stay. No slip is flagged in SEARCH.
- ACQUIRE:
  - edge on time: go to LOCKED;
  - edge with phase 0 or 1: stay in ACQUIRE, realign, slip;
  - phase==2 and no edge: go to SEARCH, slip.
- LOCKED:
  - edge on time: stay;
  - edge with phase 0 or 1: go to ACQUIRE, realign, slip;
  - phase==2 and no edge: go to SEARCH, slip.
- Each slip asserts slip_o for one cycle and increments slip_cnt_o. slip_cnt_o saturates at 2^SLIPW-1 and clears only on reset.
- locked_o = (state==LOCKED).
- valid_o = held valid AND the next-state is LOCKED, registered. valid_o therefore stays constant for all three phases of a word.
- The block performs no arithmetic; operands pass bit-exact.

## Timing
- Reset (rst_n low at a clk_3x_i edge) sets:
  - all outputs, holding registers, phase and tog_q to 0;
  - state to SEARCH; slip_cnt_o to 0.
- Reset mid-operation discards the held word.
- If tog_i=1 at reset release, the first cycle sees an edge. This is legal: SEARCH goes to ACQUIRE.
- Latency: a word launched at clk_i edge N is captured at the coincident clk_3x_i edge and is on the outputs for the next three clk_3x_i cycles, with phase_o 0, 1, 2.
- The outputs change only at the next clk_i boundary.
- Lock acquisition takes two boundaries after reset: first edge gives ACQUIRE, second on-time edge gives LOCKED.
- locked_o and valid_o rise in the same cycle that phase_o returns to 0.
- Edge and phase==2 in the same cycle is the nominal case, not a conflict. The edge wins: capture plus phase 0.
- A missing edge at phase==2 in SEARCH is not a slip.
- The multiplier consumes phase_o in place of its free-running counter.

## Test plan
- Reset, then tog_i toggling every 3 cycles with x=(100,-50), w=(511,0), ctr=5:
  - locked_o rises at the 2nd boundary;
  - outputs hold (100,-50,511,0,5) for exactly 3 cycles with phase_o 0,1,2;
  - valid_o=1, slip_cnt_o=0.
- While locked, toggle tog_i after only 2 cycles once:
  - slip_o pulses once, slip_cnt_o=1;
  - state goes to ACQUIRE, locked_o=0, phase_o realigns to 0;
  - LOCKED again at the next on-time edge.
- While locked, hold tog_i for 6 cycles:
  - at phase 2 without edge, slip_o pulses and state goes to SEARCH;
  - valid_o=0 until re-locked.
- Apply valid_i=0 on one word while locked:
  - valid_o=0 for exactly that word's 3 cycles;
  - operands still captured.
- Force 300 slips with SLIPW=8: slip_cnt_o saturates at 255.
- Assert rst_n low mid-word (phase 1): next cycle all outputs are 0 and state is SEARCH.

Source files
------------

// File: rtl/fft_r22sdf_wm_seq_if.sv
// ----------------------------------------------------------------------------
// fft_r22sdf_wm_seq_if
// Bundles the butterfly-side word bus and the multiplier-side operand bus of
// the twiddle-multiplier operand sequencer.
//   tog_i          toggle flop from the clk_i domain (inverted every clk_i)
//   valid_i        word valid (clk_i domain)
//   ctr_i          FFT counter for the word
//   x_re_i/x_im_i  butterfly output word (signed)
//   w_re_i/w_im_i  twiddle for the word (signed)
//   x_*_o, w_*_o   held operands, stable for three clk_3x_i cycles
//   ctr_o          held counter
//   phase_o        multiplier pass index 0,1,2
//   valid_o        held valid qualified by lock
//   locked_o       lock FSM in LOCKED
//   slip_o         one-cycle phase-slip pulse
//   slip_cnt_o     saturating slip count
// master: the side that drives the word and consumes the operands.
// slave : the sequencer itself.
// ----------------------------------------------------------------------------
interface fft_r22sdf_wm_seq_if #(
    parameter int DW            = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int SLIPW         = 8
);
    logic                            tog_i;
    logic                            valid_i;
    logic        [NLOG2-1:0]         ctr_i;
    logic signed [DW-1:0]            x_re_i;
    logic signed [DW-1:0]            x_im_i;
    logic signed [TWIDDLE_WIDTH-1:0] w_re_i;
    logic signed [TWIDDLE_WIDTH-1:0] w_im_i;

    logic signed [DW-1:0]            x_re_o;
    logic signed [DW-1:0]            x_im_o;
    logic signed [TWIDDLE_WIDTH-1:0] w_re_o;
    logic signed [TWIDDLE_WIDTH-1:0] w_im_o;
    logic        [NLOG2-1:0]         ctr_o;
    logic        [1:0]               phase_o;
    logic                            valid_o;
    logic                            locked_o;
    logic                            slip_o;
    logic        [SLIPW-1:0]         slip_cnt_o;

    modport master (
        output tog_i, valid_i, ctr_i, x_re_i, x_im_i, w_re_i, w_im_i,
        input  x_re_o, x_im_o, w_re_o, w_im_o, ctr_o, phase_o,
               valid_o, locked_o, slip_o, slip_cnt_o
    );

    modport slave (
        input  tog_i, valid_i, ctr_i, x_re_i, x_im_i, w_re_i, w_im_i,
        output x_re_o, x_im_o, w_re_o, w_im_o, ctr_o, phase_o,
               valid_o, locked_o, slip_o, slip_cnt_o
    );
endinterface

// File: rtl/fft_r22sdf_wm_seq.sv
// ----------------------------------------------------------------------------
// fft_r22sdf_wm_seq
// Operand sequencer for the time-shared Karatsuba twiddle multiplier of an
// R22SDF stage. Runs in the clk_3x_i domain, detects clk_i word boundaries
// from the upstream toggle, captures one word/twiddle/counter per boundary
// and holds it for three cycles while phase_o steps the multiplier through
// its three DSP passes. A lock FSM qualifies valid_o and counts phase slips.
// Ports:
//   clk_3x_i  3x clock, phase-aligned with clk_i
//   rst_n     synchronous active-low reset
//   bus       slave side of fft_r22sdf_wm_seq_if (word in, operands out)
// ----------------------------------------------------------------------------
module fft_r22sdf_wm_seq #(
    parameter int DW            = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int SLIPW         = 8
) (
    input  logic                    clk_3x_i,
    input  logic                    rst_n,
    fft_r22sdf_wm_seq_if.slave      bus
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic                            tog_q;
    logic        [1:0]               phase_q, phase_d;
    logic                            hv_q;
    logic                            valid_q, valid_d;
    logic                            slip_q, slip_d;
    logic        [SLIPW-1:0]         slip_cnt_q;
    logic signed [DW-1:0]            x_re_q, x_im_q;
    logic signed [TWIDDLE_WIDTH-1:0] w_re_q, w_im_q;
    logic        [NLOG2-1:0]         ctr_q;

    logic tog_edge;
    logic on_time;
    logic missed;

    function automatic logic [SLIPW-1:0] sat_inc(input logic [SLIPW-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // A boundary is seen in the same clk_3x_i cycle the toggle flips.
    assign tog_edge = bus.tog_i ^ tog_q;
    assign on_time  = tog_edge && (phase_q == 2'd2);
    assign missed   = !tog_edge && (phase_q == 2'd2);

    always_comb begin
        state_d = state_q;
        slip_d  = 1'b0;
        phase_d = tog_edge ? 2'd0 : ((phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1);
        unique case (state_q)
            SEARCH: begin
                if (tog_edge) state_d = ACQUIRE;
            end
            ACQUIRE, LOCKED: begin
                if (on_time) begin
                    state_d = LOCKED;
                end else if (tog_edge) begin
                    // Early boundary: realign to it and requalify.
                    state_d = ACQUIRE;
                    slip_d  = 1'b1;
                end else if (missed) begin
                    state_d = SEARCH;
                    slip_d  = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
        // Uses the valid that will be held after this edge, so valid_o is
        // constant across all three passes of a word.
        valid_d = (tog_edge ? bus.valid_i : hv_q) && (state_d == LOCKED);
    end

    always_ff @(posedge clk_3x_i) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            tog_q      <= 1'b0;
            phase_q    <= 2'd0;
            hv_q       <= 1'b0;
            valid_q    <= 1'b0;
            slip_q     <= 1'b0;
            slip_cnt_q <= '0;
            x_re_q     <= '0;
            x_im_q     <= '0;
            w_re_q     <= '0;
            w_im_q     <= '0;
            ctr_q      <= '0;
        end else begin
            state_q <= state_d;
            tog_q   <= bus.tog_i;
            phase_q <= phase_d;
            valid_q <= valid_d;
            slip_q  <= slip_d;
            if (slip_d) slip_cnt_q <= sat_inc(slip_cnt_q);
            if (tog_edge) begin
                hv_q   <= bus.valid_i;
                x_re_q <= bus.x_re_i;
                x_im_q <= bus.x_im_i;
                w_re_q <= bus.w_re_i;
                w_im_q <= bus.w_im_i;
                ctr_q  <= bus.ctr_i;
            end
        end
    end

    assign bus.x_re_o     = x_re_q;
    assign bus.x_im_o     = x_im_q;
    assign bus.w_re_o     = w_re_q;
    assign bus.w_im_o     = w_im_q;
    assign bus.ctr_o      = ctr_q;
    assign bus.phase_o    = phase_q;
    assign bus.valid_o    = valid_q;
    assign bus.locked_o   = (state_q == LOCKED);
    assign bus.slip_o     = slip_q;
    assign bus.slip_cnt_o = slip_cnt_q;

endmodule

// File: tb/tb_fft_r22sdf_wm_seq.sv
// ----------------------------------------------------------------------------
// tb_fft_r22sdf_wm_seq
// Directed bench for the twiddle-multiplier operand sequencer. A reference
// model tracks cycles since the last boundary and a lock level, and is
// compared with every output on each falling edge; literal checks at chosen
// points pin the model.
// ----------------------------------------------------------------------------
module tb_fft_r22sdf_wm_seq;
    localparam int DW = 25;
    localparam int TW = 10;
    localparam int NL = 10;
    localparam int SW = 8;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;

    fft_r22sdf_wm_seq_if #(.DW(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .SLIPW(SW)) bus ();

    fft_r22sdf_wm_seq #(.DW(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .SLIPW(SW)) dut (
        .clk_3x_i (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic                 m_tog;
    int                   m_n;      // cycles since last boundary or reset
    int                   m_lvl;    // 0 search, 1 acquire, 2 locked
    logic                 m_hv, m_valid, m_slip;
    int                   m_cnt;
    logic signed [DW-1:0] m_xr, m_xi;
    logic signed [TW-1:0] m_wr, m_wi;
    logic [NL-1:0]        m_ct;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_tog = 0; m_n = 0; m_lvl = 0; m_hv = 0; m_valid = 0; m_slip = 0;
            m_cnt = 0; m_xr = 0; m_xi = 0; m_wr = 0; m_wi = 0; m_ct = 0;
            chk_en = 1;
        end else begin
            bit e, at2;
            int nl;
            e   = (bus.tog_i != m_tog);
            at2 = (m_n % 3) == 2;
            m_slip = (m_lvl != 0) && ((e && !at2) || (!e && at2));
            if (m_slip)  nl = e ? 1 : 0;
            else if (e)  nl = (m_lvl + 1 > 2) ? 2 : m_lvl + 1;
            else         nl = m_lvl;
            m_lvl = nl;
            if (m_slip && m_cnt < 255) m_cnt++;
            if (e) begin
                m_n = 0; m_hv = bus.valid_i;
                m_xr = bus.x_re_i; m_xi = bus.x_im_i;
                m_wr = bus.w_re_i; m_wi = bus.w_im_i; m_ct = bus.ctr_i;
            end else begin
                m_n++;
            end
            m_valid = m_hv && (m_lvl == 2);
            m_tog = bus.tog_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_x_re",   64'(bus.x_re_o),     64'(m_xr));
            chk("m_x_im",   64'(bus.x_im_o),     64'(m_xi));
            chk("m_w_re",   64'(bus.w_re_o),     64'(m_wr));
            chk("m_w_im",   64'(bus.w_im_o),     64'(m_wi));
            chk("m_ctr",    64'(bus.ctr_o),      64'(m_ct));
            chk("m_phase",  64'(bus.phase_o),    64'(m_n % 3));
            chk("m_valid",  64'(bus.valid_o),    64'(m_valid));
            chk("m_locked", 64'(bus.locked_o),   64'(m_lvl == 2));
            chk("m_slip",   64'(bus.slip_o),     64'(m_slip));
            chk("m_slipcnt",64'(bus.slip_cnt_o), 64'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic word(input int len, input logic signed [DW-1:0] xr, xi,
                        input logic signed [TW-1:0] wr, wi,
                        input logic [NL-1:0] ct, input logic v);
        bus.tog_i   = ~bus.tog_i;
        bus.x_re_i  = xr; bus.x_im_i = xi;
        bus.w_re_i  = wr; bus.w_im_i = wi;
        bus.ctr_i   = ct; bus.valid_i = v;
        step(len);
    endtask

    initial begin
        rst_n = 0;
        bus.tog_i = 0; bus.valid_i = 0; bus.ctr_i = 0;
        bus.x_re_i = 0; bus.x_im_i = 0; bus.w_re_i = 0; bus.w_im_i = 0;
        step(3);
        chk("rst_locked", 64'(bus.locked_o), 64'd0);
        chk("rst_phase",  64'(bus.phase_o),  64'd0);
        rst_n = 1;

        // Acquisition: first boundary gives ACQUIRE, second gives LOCKED.
        word(3, 100, -50, 511, 0, 5, 1);
        chk("acq_locked", 64'(bus.locked_o), 64'd0);
        word(3, 100, -50, 511, 0, 5, 1);
        chk("lock_locked", 64'(bus.locked_o),   64'd1);
        chk("lock_valid",  64'(bus.valid_o),    64'd1);
        chk("lock_x_re",   64'(bus.x_re_o),     64'(100));
        chk("lock_x_im",   64'(bus.x_im_o),     64'(-50));
        chk("lock_w_re",   64'(bus.w_re_o),     64'(511));
        chk("lock_w_im",   64'(bus.w_im_o),     64'(0));
        chk("lock_ctr",    64'(bus.ctr_o),      64'd5);
        chk("lock_phase",  64'(bus.phase_o),    64'd2);
        chk("lock_slips",  64'(bus.slip_cnt_o), 64'd0);

        // Early boundary while locked.
        word(2, 11, 12, 13, 14, 6, 1);
        word(3, 21, 22, 23, 24, 7, 1);
        chk("early_cnt",    64'(bus.slip_cnt_o), 64'd1);
        chk("early_locked", 64'(bus.locked_o),   64'd0);
        word(3, 31, 32, 33, 34, 8, 1);
        chk("relock", 64'(bus.locked_o), 64'd1);

        // Missing boundary while locked.
        word(6, 41, 42, 43, 44, 9, 1);
        chk("miss_locked", 64'(bus.locked_o),   64'd0);
        chk("miss_valid",  64'(bus.valid_o),    64'd0);
        chk("miss_cnt",    64'(bus.slip_cnt_o), 64'd2);
        word(3, 51, 52, 53, 54, 10, 1);
        word(3, 61, 62, 63, 64, 11, 1);
        chk("miss_relock", 64'(bus.locked_o), 64'd1);

        // Invalid word while locked.
        word(3, 7, -7, -512, 255, 12, 0);
        chk("inv_valid",  64'(bus.valid_o),  64'd0);
        chk("inv_x_re",   64'(bus.x_re_o),   64'(7));
        chk("inv_w_re",   64'(bus.w_re_o),   64'(-512));
        chk("inv_locked", 64'(bus.locked_o), 64'd1);
        word(3, -16777216, 16777215, 1, -1, 1023, 1);
        chk("val_valid", 64'(bus.valid_o), 64'd1);

        // Slip counter saturation: boundaries every cycle.
        for (int i = 0; i < 310; i++) word(1, i, -i, i[9:0], 0, i[9:0], 1);
        chk("sat_cnt", 64'(bus.slip_cnt_o), 64'd255);
        word(3, 1, 2, 3, 4, 1, 1);
        word(3, 1, 2, 3, 4, 2, 1);
        word(3, 1, 2, 3, 4, 3, 1);
        chk("sat_relock", 64'(bus.locked_o),   64'd1);
        chk("sat_hold",   64'(bus.slip_cnt_o), 64'd255);

        // Reset mid-word at phase 1.
        bus.tog_i = ~bus.tog_i; bus.x_re_i = 99; bus.ctr_i = 77;
        step(2);
        chk("mid_phase", 64'(bus.phase_o), 64'd1);
        rst_n = 0;
        bus.tog_i = 1;
        step(1);
        chk("mr_x_re",   64'(bus.x_re_o),     64'd0);
        chk("mr_ctr",    64'(bus.ctr_o),      64'd0);
        chk("mr_phase",  64'(bus.phase_o),    64'd0);
        chk("mr_locked", 64'(bus.locked_o),   64'd0);
        chk("mr_valid",  64'(bus.valid_o),    64'd0);
        chk("mr_cnt",    64'(bus.slip_cnt_o), 64'd0);
        rst_n = 1;
        // tog_i=1 at release: the first cycle sees a boundary.
        step(3);
        chk("rel_x_re", 64'(bus.x_re_o), 64'(99));
        word(3, 5, 6, 7, 8, 9, 1);
        chk("rel_locked", 64'(bus.locked_o), 64'd1);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
